// File: rtl/alu_arbiter_if.sv
// Request/response channels between the requesters, the response consumer and alu_arbiter.
interface alu_arbiter_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 16
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [1:0]    req0_op;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [1:0]    req1_op;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [RW-1:0] rsp_data;

    // Requester/consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for the shared arithmetic unit: accept, issue one cycle, capture, respond.
module alu_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    output logic [1:0]    o_alu_s1,
    output logic          o_alu_en,
    input  logic [RW-1:0] i_alu_out,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_lg;
    logic          r_id;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [1:0]    r_alu_s1;
    logic [RW-1:0] r_rsp_data;

    logic          w_req_any;
    logic          w_gnt;
    logic          w_accept;

    // Grant: a lone requester wins; on a tie the one that was not granted last wins
    always_comb begin
        w_req_any = bus.req0_valid | bus.req1_valid;
        w_gnt     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = ~r_lg;
        end else begin
            w_gnt = bus.req1_valid;
        end
        w_accept  = (r_state == S_IDLE) && w_req_any;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; readies only ever rise in IDLE
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        o_alu_en       = 1'b0;
        o_busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy         = 1'b0;
                bus.req0_ready = bus.req0_valid && !w_gnt;
                bus.req1_ready = bus.req1_valid && w_gnt;
            end
            S_ISSUE: o_alu_en      = 1'b1;
            S_RESP:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand/id capture on accept, result capture at the end of WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lg       <= 1'b1;
            r_id       <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_s1   <= 2'b00;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_lg     <= w_gnt;
                r_id     <= w_gnt;
                r_alu_a  <= w_gnt ? bus.req1_a  : bus.req0_a;
                r_alu_b  <= w_gnt ? bus.req1_b  : bus.req0_b;
                r_alu_s1 <= w_gnt ? bus.req1_op : bus.req0_op;
            end
            if (r_state == S_WAIT) begin
                r_rsp_data <= i_alu_out;
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_s1     = r_alu_s1;
    assign bus.rsp_id   = r_id;
    assign bus.rsp_data = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural arithmetic unit and an in-order scoreboard.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_s1;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        busy;

    alu_arbiter_if u_if ();

    alu_arbiter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (u_if),
        .o_alu_a  (alu_a),
        .o_alu_b  (alu_b),
        .o_alu_s1 (alu_s1),
        .o_alu_en (alu_en),
        .i_alu_out(alu_out),
        .o_busy   (busy)
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          en_cnt = 0;
    logic        prev_en = 1'b0;
    logic [15:0] wait_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural arithmetic unit: registered, enable-gated, clears when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
        end else if (alu_en) begin
            case (alu_s1)
                2'b00:   alu_out <= {7'd0, {1'b0, alu_a} + {1'b0, alu_b}};
                2'b01:   alu_out <= {7'd0, {1'b0, alu_a} - {1'b0, alu_b}};
                2'b10:   alu_out <= 16'(alu_a) * 16'(alu_b);
                default: alu_out <= (alu_b == 8'd0) ? 16'hFFFF : 16'(alu_a / alu_b);
            endcase
        end else begin
            alu_out <= '0;
        end
    end

    function automatic logic [15:0] ref_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        case (op)
            2'b00:   r = ia + ib;
            2'b01:   r = (ia - ib) & 32'h1FF;
            2'b10:   r = ia * ib;
            default: r = (ib == 0) ? 32'hFFFF : ia / ib;
        endcase
        return 16'(r);
    endfunction

    // Push expectations on accepted requests; track enable pulses and the WAIT-cycle unit output
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.req0_valid && u_if.req0_ready)
                sb.push_back('{id: 1'b0, data: ref_fn(u_if.req0_a, u_if.req0_b, u_if.req0_op), acc: cyc});
            if (u_if.req1_valid && u_if.req1_ready)
                sb.push_back('{id: 1'b1, data: ref_fn(u_if.req1_a, u_if.req1_b, u_if.req1_op), acc: cyc});
            if (alu_en) en_cnt <= en_cnt + 1;
            if (prev_en) wait_out <= alu_out;
            prev_en <= alu_en;
        end else begin
            prev_en <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_reqs();
        u_if.req0_valid = 1'b0; u_if.req0_a = '0; u_if.req0_b = '0; u_if.req0_op = 2'b00;
        u_if.req1_valid = 1'b0; u_if.req1_a = '0; u_if.req1_b = '0; u_if.req1_op = 2'b00;
    endtask

    task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output bit ok);
        @(posedge clk); #1;
        if (id) begin
            u_if.req1_a = a; u_if.req1_b = b; u_if.req1_op = op; u_if.req1_valid = 1'b1;
        end else begin
            u_if.req0_a = a; u_if.req0_b = b; u_if.req0_op = op; u_if.req0_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? u_if.req1_ready : u_if.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (id) u_if.req1_valid = 1'b0;
        else    u_if.req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (u_if.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.rsp_ready = 1'b1;
        clear_reqs();
        repeat (2) @(negedge clk);
        total++; if (u_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", u_if.rsp_valid); end
        total++; if (u_if.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b exp=0", u_if.rsp_id); end
        total++; if (u_if.rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", u_if.rsp_data); end
        total++; if ({alu_a, alu_b, alu_s1, alu_en} !== 19'd0) begin bad++; $display("FAIL reset_alu_outs got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_s1, alu_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({u_if.req0_ready, u_if.req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", u_if.req0_ready, u_if.req1_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        bit   ok;
        int   e0;
        exp_t e;
        @(posedge clk); #1;
        e0 = en_cnt;
        u_if.req0_a = 8'hF0; u_if.req0_b = 8'h20; u_if.req0_op = 2'b00; u_if.req0_valid = 1'b1;
        @(negedge clk);
        total++; if (u_if.req0_ready !== 1'b1) begin bad++; $display("FAIL add_ready0 got=%b exp=1", u_if.req0_ready); end
        total++; if (u_if.req1_ready !== 1'b0) begin bad++; $display("FAIL add_ready1 got=%b exp=0", u_if.req1_ready); end
        @(posedge clk); #1;
        u_if.req0_valid = 1'b0;
        wait_rsp(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL add_rsp_timeout got=none exp=rsp_valid"); end
        else if (sb.size() == 0) begin total++; bad++; $display("FAIL add_sb_empty got=0 exp=1 entry"); end
        else begin
            e = sb.pop_front();
            total++; if (u_if.rsp_id !== 1'b0) begin bad++; $display("FAIL add_id got=%b exp=0", u_if.rsp_id); end
            total++; if (u_if.rsp_data !== 16'h0110) begin bad++; $display("FAIL add_data got=%h exp=0110", u_if.rsp_data); end
            total++; if (u_if.rsp_data !== e.data) begin bad++; $display("FAIL add_sb_data got=%h exp=%h", u_if.rsp_data, e.data); end
            total++; if (cyc - e.acc != 3) begin bad++; $display("FAIL add_latency got=%0d exp=3", cyc - e.acc); end
            total++; if (en_cnt - e0 != 1) begin bad++; $display("FAIL add_en_pulses got=%0d exp=1", en_cnt - e0); end
            total++; if ({alu_a, alu_b, alu_s1} !== {8'hF0, 8'h20, 2'b00}) begin bad++; $display("FAIL add_alu_hold got=%h/%h/%b exp=f0/20/00", alu_a, alu_b, alu_s1); end
        end
        @(negedge clk);
        total++; if ({busy, u_if.rsp_valid} !== 2'b00) begin bad++; $display("FAIL add_back_idle got=%b%b exp=00", busy, u_if.rsp_valid); end
    endtask

    task automatic test_contention();
        int   n = 0;
        bit   a0, a1;
        exp_t e;
        rst_n = 1'b0;
        u_if.req0_a = 8'h0F; u_if.req0_b = 8'h11; u_if.req0_op = 2'b10; u_if.req0_valid = 1'b1;
        u_if.req1_a = 8'h05; u_if.req1_b = 8'h07; u_if.req1_op = 2'b01; u_if.req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if ({u_if.req0_ready, u_if.req1_ready} !== 2'b10) begin bad++; $display("FAIL cont_first_grant got=%b%b exp=10", u_if.req0_ready, u_if.req1_ready); end
        for (int c = 0; c < 40 && n < 2; c++) begin
            if (c != 0) @(negedge clk);
            a0 = u_if.req0_valid && u_if.req0_ready;
            a1 = u_if.req1_valid && u_if.req1_ready;
            if (u_if.rsp_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                total++; if (u_if.rsp_id !== 1'(n)) begin bad++; $display("FAIL cont_id%0d got=%b exp=%0d", n, u_if.rsp_id, n); end
                total++; if (u_if.rsp_data !== e.data) begin bad++; $display("FAIL cont_sb%0d got=%h exp=%h", n, u_if.rsp_data, e.data); end
                if (n == 0) begin
                    total++; if (u_if.rsp_data !== 16'h00FF) begin bad++; $display("FAIL cont_mul got=%h exp=00ff", u_if.rsp_data); end
                end else begin
                    total++; if ({u_if.rsp_data[8], u_if.rsp_data[7:0]} !== {1'b1, 8'hFE}) begin bad++; $display("FAIL cont_sub got=%h exp=borrow+fe", u_if.rsp_data); end
                end
                n++;
            end
            @(posedge clk); #1;
            if (a0) u_if.req0_valid = 1'b0;
            if (a1) u_if.req1_valid = 1'b0;
        end
        total++; if (n != 2) begin bad++; $display("FAIL cont_count got=%0d exp=2", n); end
    endtask

    task automatic test_fairness();
        int   n = 0;
        int   left0 = 4;
        int   left1 = 4;
        int   last = 0;
        bit   a0, a1;
        exp_t e;
        @(posedge clk); #1;
        u_if.req0_a = 8'h80; u_if.req0_b = 8'h90; u_if.req0_op = 2'b00; u_if.req0_valid = 1'b1;
        u_if.req1_a = 8'hFF; u_if.req1_b = 8'hFF; u_if.req1_op = 2'b10; u_if.req1_valid = 1'b1;
        for (int c = 0; c < 80 && n < 8; c++) begin
            @(negedge clk);
            a0 = u_if.req0_valid && u_if.req0_ready;
            a1 = u_if.req1_valid && u_if.req1_ready;
            if (a0 && a1) begin total++; bad++; $display("FAIL fair_both_ready got=11 exp=one-hot"); end
            if (u_if.rsp_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                total++; if (u_if.rsp_id !== 1'(n % 2)) begin bad++; $display("FAIL fair_id%0d got=%b exp=%0d", n, u_if.rsp_id, n % 2); end
                total++; if (u_if.rsp_data !== ((n % 2) ? 16'hFE01 : 16'h0110)) begin bad++; $display("FAIL fair_data%0d got=%h exp=%h", n, u_if.rsp_data, e.data); end
                if (n > 0) begin
                    total++; if (cyc - last != 4) begin bad++; $display("FAIL fair_interval%0d got=%0d exp=4", n, cyc - last); end
                end
                last = cyc;
                n++;
            end
            @(posedge clk); #1;
            if (a0) begin left0--; if (left0 == 0) u_if.req0_valid = 1'b0; end
            if (a1) begin left1--; if (left1 == 0) u_if.req1_valid = 1'b0; end
        end
        total++; if (n != 8) begin bad++; $display("FAIL fair_count got=%0d exp=8", n); end
    endtask

    task automatic test_back_pressure();
        bit          ok;
        logic [15:0] held;
        exp_t        e;
        u_if.rsp_ready = 1'b0;
        send(1'b1, 8'h33, 8'h44, 2'b00, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_accept got=none exp=ready1"); end
        u_if.req0_a = 8'h10; u_if.req0_b = 8'h01; u_if.req0_op = 2'b01; u_if.req0_valid = 1'b1;
        wait_rsp(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_rsp_timeout got=none exp=rsp_valid"); end
        held = u_if.rsp_data;
        total++; if (held !== 16'h0077) begin bad++; $display("FAIL bp_data got=%h exp=0077", held); end
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            total++;
            if ({u_if.rsp_valid, u_if.rsp_id, u_if.rsp_data, u_if.req0_ready, u_if.req1_ready, busy, alu_en}
                !== {1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold%0d got=v%b id%b d%h r%b%b busy%b en%b exp=v1 id1 d0077 r00 busy1 en0",
                         k, u_if.rsp_valid, u_if.rsp_id, u_if.rsp_data, u_if.req0_ready, u_if.req1_ready, busy, alu_en);
            end
        end
        @(posedge clk); #1;
        u_if.rsp_ready = 1'b1;
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++; if ({u_if.rsp_id, u_if.rsp_data} !== {e.id, e.data}) begin bad++; $display("FAIL bp_sb got=%b/%h exp=%b/%h", u_if.rsp_id, u_if.rsp_data, e.id, e.data); end
        end else begin
            total++; bad++; $display("FAIL bp_sb_empty got=0 exp=1 entry");
        end
        @(negedge clk);
        total++; if ({busy, u_if.req0_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=busy%b ready0%b exp=busy0 ready0=1", busy, u_if.req0_ready); end
        @(posedge clk); #1;
        u_if.req0_valid = 1'b0;
        wait_rsp(10, ok);
        if (ok && sb.size() != 0) begin
            e = sb.pop_front();
            total++; if ({u_if.rsp_id, u_if.rsp_data} !== {1'b0, 16'h000F}) begin bad++; $display("FAIL bp_next got=%b/%h exp=0/000f", u_if.rsp_id, u_if.rsp_data); end
        end else begin
            total++; bad++; $display("FAIL bp_next_timeout got=none exp=rsp_valid");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit   ok;
        int   n = 0;
        bit   a0, a1;
        exp_t e;
        send(1'b0, 8'h12, 8'h34, 2'b10, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_accept got=none exp=ready0"); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({u_if.rsp_valid, u_if.rsp_id, u_if.rsp_data, alu_a, alu_b, alu_s1, alu_en, busy} !== 38'd0) begin
            bad++;
            $display("FAIL rst_async got=v%b id%b d%h a%h b%h s%b en%b busy%b exp=all0",
                     u_if.rsp_valid, u_if.rsp_id, u_if.rsp_data, alu_a, alu_b, alu_s1, alu_en, busy);
        end
        sb.delete();
        u_if.req0_a = 8'h01; u_if.req0_b = 8'h02; u_if.req0_op = 2'b00; u_if.req0_valid = 1'b1;
        u_if.req1_a = 8'h03; u_if.req1_b = 8'h04; u_if.req1_op = 2'b00; u_if.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (u_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp%0d got=%b exp=0", k, u_if.rsp_valid); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40 && n < 2; c++) begin
            @(negedge clk);
            a0 = u_if.req0_valid && u_if.req0_ready;
            a1 = u_if.req1_valid && u_if.req1_ready;
            if (u_if.rsp_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if ({u_if.rsp_id, u_if.rsp_data} !== {1'(n), (n == 0) ? 16'h0003 : 16'h0007}) begin
                    bad++;
                    $display("FAIL rst_after%0d got=%b/%h exp=%0d/%h", n, u_if.rsp_id, u_if.rsp_data, n, e.data);
                end
                n++;
            end
            @(posedge clk); #1;
            if (a0) u_if.req0_valid = 1'b0;
            if (a1) u_if.req1_valid = 1'b0;
        end
        total++; if (n != 2) begin bad++; $display("FAIL rst_after_count got=%0d exp=2", n); end
    endtask

    task automatic test_divide();
        bit   ok;
        exp_t e;
        send(1'b1, 8'd200, 8'd7, 2'b11, ok);
        total++; if (!ok) begin bad++; $display("FAIL div_accept got=none exp=ready1"); end
        wait_rsp(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL div_rsp_timeout got=none exp=rsp_valid"); end
        else if (sb.size() == 0) begin total++; bad++; $display("FAIL div_sb_empty got=0 exp=1 entry"); end
        else begin
            e = sb.pop_front();
            total++; if (u_if.rsp_id !== 1'b1) begin bad++; $display("FAIL div_id got=%b exp=1", u_if.rsp_id); end
            total++; if (u_if.rsp_data !== 16'h001C) begin bad++; $display("FAIL div_data got=%h exp=001c", u_if.rsp_data); end
            total++; if (u_if.rsp_data !== wait_out) begin bad++; $display("FAIL div_wait_capture got=%h exp=%h", u_if.rsp_data, wait_out); end
            total++; if (u_if.rsp_data !== e.data) begin bad++; $display("FAIL div_sb got=%h exp=%h", u_if.rsp_data, e.data); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_fairness();
        test_back_pressure();
        test_reset_mid_op();
        test_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
